sbu_verdict_filter: RTL and testbench

- Receiver/consumer for the firewall's classified AXI4-Stream.
- Sits on the sbu2cxp path, after the store-and-forward FIFO. The upstream classifier stamps a per-packet verdict in tuser[0] on every beat; this block reads the first-beat verdict and either forwards or discards the whole packet.
- Keeps pass/drop packet counters for host readout through existing register logic.
- Output is a registered AXI4-Stream with 1-cycle latency and full throughput.

---
 rtl/sbu_verdict_filter_if.sv | 17 +
 rtl/sbu_verdict_filter.sv | 120 ++++++++++++
 tb/tb_sbu_verdict_filter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sbu_verdict_filter_if.sv
// AXI4-Stream bundle used on both sides of the verdict filter.
interface sbu_verdict_filter_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 12,
  parameter int ID_W   = 3
);
  logic                tvalid;
  logic                tready;
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic [USER_W-1:0]   tuser;
  logic [ID_W-1:0]     tid;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, tid, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, tid, output tready);
endinterface

// File: rtl/sbu_verdict_filter.sv
// Forwards or discards whole AXI4-Stream packets using the verdict stamped on
// each packet's first beat, with pass/drop packet counters for host readout.
module sbu_verdict_filter #(
  parameter int DATA_W   = 256,
  parameter int USER_W   = 12,
  parameter int ID_W     = 3,
  parameter int CNT_W    = 32,
  parameter bit PASS_VAL = 1'b1
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  sbu_verdict_filter_if.slave  s_axis,
  sbu_verdict_filter_if.master m_axis,
  input  logic                 bypass,
  input  logic                 cnt_clear,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_e;

  state_e                state_q, state_d;
  logic                  mValid_q, mValid_d;
  logic [DATA_W-1:0]     mData_q, mData_d;
  logic [DATA_W/8-1:0]   mKeep_q, mKeep_d;
  logic                  mLast_q, mLast_d;
  logic [USER_W-1:0]     mUser_q, mUser_d;
  logic [ID_W-1:0]       mId_q, mId_d;
  logic [CNT_W-1:0]      passCnt_q, passCnt_d;
  logic [CNT_W-1:0]      dropCnt_q, dropCnt_d;
  logic                  sReady;
  logic                  accept;
  logic                  fwdFirst;
  logic                  loadBeat;

  // Ready is forced low while reset is held; a packet being discarded never
  // waits on the output stage.
  always_comb begin
    sReady   = ap_rst_n && ((state_q == DROP) || !mValid_q || m_axis.tready);
    accept   = s_axis.tvalid && sReady;
    fwdFirst = (s_axis.tuser[0] == PASS_VAL) || bypass;
    loadBeat = accept && ((state_q == PASS) || ((state_q == IDLE) && fwdFirst));

    state_d   = state_q;
    mValid_d  = mValid_q;
    mData_d   = mData_q;
    mKeep_d   = mKeep_q;
    mLast_d   = mLast_q;
    mUser_d   = mUser_q;
    mId_d     = mId_q;
    passCnt_d = passCnt_q;
    dropCnt_d = dropCnt_q;

    if (loadBeat) begin
      mValid_d = 1'b1;
      mData_d  = s_axis.tdata;
      mKeep_d  = s_axis.tkeep;
      mLast_d  = s_axis.tlast;
      mUser_d  = s_axis.tuser;
      mId_d    = s_axis.tid;
    end else if (m_axis.tready) begin
      mValid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (fwdFirst) passCnt_d = passCnt_q + CNT_W'(1);
          else          dropCnt_d = dropCnt_q + CNT_W'(1);
          if (!s_axis.tlast) state_d = fwdFirst ? PASS : DROP;
        end
      end
      PASS, DROP: begin
        if (accept && s_axis.tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A clear wins over an increment landing in the same cycle.
    if (cnt_clear) begin
      passCnt_d = '0;
      dropCnt_d = '0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= IDLE;
      mValid_q  <= 1'b0;
      mData_q   <= '0;
      mKeep_q   <= '0;
      mLast_q   <= 1'b0;
      mUser_q   <= '0;
      mId_q     <= '0;
      passCnt_q <= '0;
      dropCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mValid_q  <= mValid_d;
      mData_q   <= mData_d;
      mKeep_q   <= mKeep_d;
      mLast_q   <= mLast_d;
      mUser_q   <= mUser_d;
      mId_q     <= mId_d;
      passCnt_q <= passCnt_d;
      dropCnt_q <= dropCnt_d;
    end
  end

  assign s_axis.tready = sReady;
  assign m_axis.tvalid = mValid_q;
  assign m_axis.tdata  = mData_q;
  assign m_axis.tkeep  = mKeep_q;
  assign m_axis.tlast  = mLast_q;
  assign m_axis.tuser  = mUser_q;
  assign m_axis.tid    = mId_q;
  assign pass_cnt      = passCnt_q;
  assign drop_cnt      = dropCnt_q;

endmodule

// File: tb/tb_sbu_verdict_filter.sv
// Self-checking bench for sbu_verdict_filter: a packet-level scoreboard watches
// every cycle while directed, table-driven and random traffic is applied.
module tb_sbu_verdict_filter;

  localparam int DATA_W  = 256;
  localparam int USER_W  = 12;
  localparam int ID_W    = 3;
  localparam int CNT_W   = 4;
  localparam int KEEP_W  = DATA_W / 8;
  localparam int CNT_MOD = 1 << CNT_W;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [USER_W-1:0] user;
    logic [ID_W-1:0]   id;
  } beat_t;

  typedef struct {
    bit verdict;
    bit byp;
    bit expValid;
    int expPass;
    int expDrop;
  } vec_t;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n = 1'b0;
  logic             bypass = 1'b0;
  logic             cnt_clear = 1'b0;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] drop_cnt;

  sbu_verdict_filter_if #(.DATA_W(DATA_W), .USER_W(USER_W), .ID_W(ID_W)) sIf ();
  sbu_verdict_filter_if #(.DATA_W(DATA_W), .USER_W(USER_W), .ID_W(ID_W)) mIf ();

  sbu_verdict_filter #(
    .DATA_W(DATA_W), .USER_W(USER_W), .ID_W(ID_W), .CNT_W(CNT_W), .PASS_VAL(1'b1)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .s_axis   (sIf),
    .m_axis   (mIf),
    .bypass   (bypass),
    .cnt_clear(cnt_clear),
    .pass_cnt (pass_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  int    checks = 0;
  int    failures = 0;
  beat_t expQ[$];
  bit    mFirst = 1'b1;
  bit    mFwd = 1'b0;
  int    mPass = 0;
  int    mDrop = 0;
  int    outBeats = 0;
  int    outLast = 0;
  bit    latPending = 1'b0;
  beat_t latBeat;
  bit    holdPending = 1'b0;
  beat_t holdBeat;
  int    readyMode = 0;
  int    patIdx = 0;
  int    lastWait = 0;

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: event missing or unexpected at %0t", name, $time);
  endtask

  // Downstream ready: always high, the 1,0,0,1 pattern, random, or held low.
  always @(posedge ap_clk) begin
    #1;
    case (readyMode)
      0:       mIf.tready = 1'b1;
      1: begin
        mIf.tready = ((patIdx % 4) == 0) || ((patIdx % 4) == 3);
        patIdx++;
      end
      2:       mIf.tready = 1'($urandom_range(0, 1));
      default: mIf.tready = 1'b0;
    endcase
  end

  // Packet-level reference: verdict per packet, queue of beats owed downstream,
  // counters modulo 2^CNT_W, all sampled mid-cycle.
  always @(negedge ap_clk) begin : monitorBlk
    beat_t cur;
    beat_t inB;
    beat_t expB;
    logic  expReady;
    if (!ap_rst_n) begin
      expQ.delete();
      mFirst      = 1'b1;
      mFwd        = 1'b0;
      mPass       = 0;
      mDrop       = 0;
      latPending  = 1'b0;
      holdPending = 1'b0;
    end else begin
      cur = '{mIf.tdata, mIf.tkeep, mIf.tlast, mIf.tuser, mIf.tid};
      checkOutput("passCnt", pass_cnt, mPass);
      checkOutput("dropCnt", drop_cnt, mDrop);
      expReady = (!mFirst && !mFwd) ? 1'b1 : (!mIf.tvalid || mIf.tready);
      checkOutput("sReady", sIf.tready, expReady);
      if (latPending) begin
        checkOutput("latValid", mIf.tvalid, 1);
        checkOutput("latData", cur.data, latBeat.data);
      end
      latPending = 1'b0;
      if (holdPending) begin
        checkOutput("holdValid", mIf.tvalid, 1);
        checkOutput("holdData", cur.data, holdBeat.data);
        checkOutput("holdSide", {cur.keep, cur.last, cur.user, cur.id},
                    {holdBeat.keep, holdBeat.last, holdBeat.user, holdBeat.id});
      end
      holdPending = mIf.tvalid && !mIf.tready;
      holdBeat    = cur;
      if (mIf.tvalid && mIf.tready) begin
        if (expQ.size() == 0) begin
          reportFail("spuriousOutBeat");
        end else begin
          expB = expQ.pop_front();
          checkOutput("outData", cur.data, expB.data);
          checkOutput("outSide", {cur.keep, cur.last, cur.user, cur.id},
                      {expB.keep, expB.last, expB.user, expB.id});
          outBeats++;
          if (cur.last) outLast++;
        end
      end
      if (sIf.tvalid && sIf.tready) begin
        inB = '{sIf.tdata, sIf.tkeep, sIf.tlast, sIf.tuser, sIf.tid};
        if (mFirst) begin
          mFwd = sIf.tuser[0] || bypass;
          if (mFwd) mPass = (mPass + 1) % CNT_MOD;
          else      mDrop = (mDrop + 1) % CNT_MOD;
        end
        if (mFwd) begin
          expQ.push_back(inB);
          latPending = 1'b1;
          latBeat    = inB;
        end
        mFirst = sIf.tlast;
      end
      if (cnt_clear) begin
        mPass = 0;
        mDrop = 0;
      end
    end
  end

  function automatic logic [DATA_W-1:0] randData();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic driveIdle();
    sIf.tvalid = 1'b0;
    sIf.tlast  = 1'b0;
    bypass     = 1'b0;
  endtask

  // Presents one beat and returns one step after the edge that accepted it.
  task automatic sendBeat(input bit verdict, input bit last, input bit byp, input bit clr);
    logic [USER_W-1:0] u;
    u          = USER_W'($urandom);
    u[0]       = verdict;
    sIf.tvalid = 1'b1;
    sIf.tdata  = randData();
    sIf.tkeep  = KEEP_W'($urandom);
    sIf.tlast  = last;
    sIf.tuser  = u;
    sIf.tid    = ID_W'($urandom);
    bypass     = byp;
    cnt_clear  = clr;
    lastWait   = 0;
    forever begin
      @(negedge ap_clk);
      if (sIf.tready) break;
      lastWait++;
      if (lastWait > 200) begin
        reportFail("acceptTimeout");
        break;
      end
    end
    @(posedge ap_clk);
    #1;
    cnt_clear = 1'b0;
  endtask

  task automatic sendPacket(input int nBeats, input bit verdict, input bit byp,
                            input bit flip, input bit clr, output int stalls);
    bit v;
    stalls = 0;
    for (int b = 0; b < nBeats; b++) begin
      if (b == 0)  v = verdict;
      else if (flip) v = ~verdict;
      else v = 1'($urandom_range(0, 1));
      sendBeat(v, b == nBeats - 1, (b == 0) ? byp : 1'($urandom_range(0, 1)),
               (b == 0) ? clr : 1'b0);
      stalls += lastWait;
    end
    driveIdle();
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((expQ.size() != 0 || mIf.tvalid) && n < 500) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    if (n >= 500) reportFail("drainTimeout");
    @(posedge ap_clk);
    #1;
  endtask

  task automatic clearCounters();
    cnt_clear = 1'b1;
    @(posedge ap_clk);
    #1;
    cnt_clear = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    sendBeat(v.verdict, 1'b1, v.byp, 1'b0);
    driveIdle();
    checkOutput("vecValid", mIf.tvalid, v.expValid);
    checkOutput("vecPass", pass_cnt, v.expPass);
    checkOutput("vecDrop", drop_cnt, v.expDrop);
    @(posedge ap_clk);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    reportFail("globalTimeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    vec_t vecs[4];
    int   st;
    int   tot;
    int   ob0;
    int   ol0;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 1, 0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1, 1};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 2, 1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 3, 1};

    mIf.tready = 1'b0;
    sIf.tdata  = '0;
    sIf.tkeep  = '0;
    sIf.tuser  = '0;
    sIf.tid    = '0;
    driveIdle();
    #1;
    checkOutput("rstReady", sIf.tready, 0);
    checkOutput("rstValid", mIf.tvalid, 0);
    repeat (3) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    #1;
    checkOutput("relReady", sIf.tready, 1);
    checkOutput("relValid", mIf.tvalid, 0);
    checkOutput("relData", mIf.tdata, 0);
    checkOutput("relPass", pass_cnt, 0);
    checkOutput("relDrop", drop_cnt, 0);
    @(posedge ap_clk);
    #1;

    $display("[TB] single-beat verdict table");
    foreach (vecs[i]) applyStimulus(vecs[i]);

    $display("[TB] three 4-beat pass packets");
    clearCounters();
    ob0 = outBeats;
    for (int p = 0; p < 3; p++) sendPacket(4, 1'b1, 1'b0, 1'b0, 1'b0, st);
    waitDrain();
    checkOutput("t1Beats", outBeats - ob0, 12);
    checkOutput("t1Pass", pass_cnt, 3);
    checkOutput("t1Drop", drop_cnt, 0);

    $display("[TB] pass3 drop5 pass1 back-to-back");
    clearCounters();
    ob0 = outBeats;
    ol0 = outLast;
    sendPacket(3, 1'b1, 1'b0, 1'b0, 1'b0, st);
    sendPacket(5, 1'b0, 1'b0, 1'b0, 1'b0, st);
    checkOutput("t2DropStall", st, 0);
    sendPacket(1, 1'b1, 1'b0, 1'b0, 1'b0, st);
    waitDrain();
    checkOutput("t2Beats", outBeats - ob0, 4);
    checkOutput("t2Lasts", outLast - ol0, 2);
    checkOutput("t2Pass", pass_cnt, 2);
    checkOutput("t2Drop", drop_cnt, 1);

    $display("[TB] drop packet with output held off");
    sendBeat(1'b0, 1'b0, 1'b0, 1'b0);
    readyMode = 3;
    tot = 0;
    for (int b = 0; b < 4; b++) begin
      sendBeat(1'($urandom_range(0, 1)), b == 3, 1'b0, 1'b0);
      tot += lastWait;
    end
    driveIdle();
    readyMode = 0;
    checkOutput("dropNoStall", tot, 0);
    checkOutput("dropCnt3", drop_cnt, 2);

    $display("[TB] 8-beat pass packet under 1,0,0,1 backpressure");
    clearCounters();
    ob0 = outBeats;
    patIdx = 0;
    readyMode = 1;
    sendPacket(8, 1'b1, 1'b0, 1'b0, 1'b0, st);
    waitDrain();
    readyMode = 0;
    checkOutput("t3Stalled", st > 0, 1);
    checkOutput("t3Beats", outBeats - ob0, 8);
    checkOutput("t3Pass", pass_cnt, 1);

    $display("[TB] bypass and late verdict flip");
    clearCounters();
    ob0 = outBeats;
    sendPacket(3, 1'b0, 1'b1, 1'b0, 1'b0, st);
    sendPacket(3, 1'b0, 1'b1, 1'b0, 1'b0, st);
    waitDrain();
    checkOutput("t4Beats", outBeats - ob0, 6);
    checkOutput("t4Pass", pass_cnt, 2);
    checkOutput("t4Drop", drop_cnt, 0);
    sendPacket(4, 1'b1, 1'b0, 1'b1, 1'b0, st);
    waitDrain();
    checkOutput("t4FlipBeats", outBeats - ob0, 10);
    checkOutput("t4FlipPass", pass_cnt, 3);

    $display("[TB] counter wrap and clear collision");
    clearCounters();
    for (int p = 0; p < 15; p++) sendPacket(1, 1'b1, 1'b0, 1'b0, 1'b0, st);
    waitDrain();
    checkOutput("wrap15", pass_cnt, 15);
    sendPacket(1, 1'b1, 1'b0, 1'b0, 1'b0, st);
    checkOutput("wrap16", pass_cnt, 0);
    sendPacket(1, 1'b1, 1'b0, 1'b0, 1'b0, st);
    sendPacket(1, 1'b0, 1'b0, 1'b0, 1'b0, st);
    checkOutput("preClrPass", pass_cnt, 1);
    sendPacket(1, 1'b1, 1'b0, 1'b0, 1'b1, st);
    checkOutput("clrPass", pass_cnt, 0);
    checkOutput("clrDrop", drop_cnt, 0);
    waitDrain();

    $display("[TB] reset in the middle of a pass packet");
    clearCounters();
    sendBeat(1'b1, 1'b0, 1'b0, 1'b0);
    sIf.tdata = randData();
    ap_rst_n  = 1'b0;
    #1;
    checkOutput("midRstValid", mIf.tvalid, 0);
    checkOutput("midRstData", mIf.tdata, 0);
    checkOutput("midRstReady", sIf.tready, 0);
    checkOutput("midRstPass", pass_cnt, 0);
    driveIdle();
    @(posedge ap_clk);
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    #1;
    checkOutput("postRstReady", sIf.tready, 1);
    ob0 = outBeats;
    sendPacket(2, 1'b0, 1'b0, 1'b0, 1'b0, st);
    waitDrain();
    checkOutput("postRstBeats", outBeats - ob0, 0);
    checkOutput("postRstDrop", drop_cnt, 1);
    checkOutput("postRstPass", pass_cnt, 0);

    $display("[TB] random traffic against the reference model");
    readyMode = 2;
    for (int p = 0; p < 60; p++) begin
      sendPacket($urandom_range(1, 6), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), 1'b0, ($urandom_range(0, 7) == 0), st);
      repeat ($urandom_range(0, 2)) begin
        @(posedge ap_clk);
        #1;
      end
    end
    waitDrain();
    readyMode = 0;
    checkOutput("finalQueueEmpty", expQ.size(), 0);

    repeat (3) @(posedge ap_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
